// File: rtl/register_file_if.sv
// Register file bus: write data/enables in, register contents out.
interface register_file_if;
  logic [15:0] r_input;
  logic        r_write;
  logic        r_backup;
  logic        r_restore;
  logic [3:0]  page_input;
  logic        page_write;
  logic [2:0]  compare_input;
  logic        compare_write;
  logic [15:0] stack_pointer_input;
  logic        stack_pointer_write;
  logic [15:0] return_address_input;
  logic        return_address_write;
  logic [8:0]  interrupt_input;
  logic        interrupt_write;
  logic [15:0] r_output;
  logic [15:0] flag_output;
  logic [15:0] stack_pointer_output;
  logic [15:0] return_address_output;

  modport master (
    output r_input, r_write, r_backup, r_restore,
    output page_input, page_write,
    output compare_input, compare_write,
    output stack_pointer_input, stack_pointer_write,
    output return_address_input, return_address_write,
    output interrupt_input, interrupt_write,
    input  r_output, flag_output,
    input  stack_pointer_output, return_address_output
  );

  modport slave (
    input  r_input, r_write, r_backup, r_restore,
    input  page_input, page_write,
    input  compare_input, compare_write,
    input  stack_pointer_input, stack_pointer_write,
    input  return_address_input, return_address_write,
    input  interrupt_input, interrupt_write,
    output r_output, flag_output,
    output stack_pointer_output, return_address_output
  );
endinterface

// File: rtl/register_file.sv
// Accumulator, flags, SP and return-address registers; all outputs registered.
// REGISTER_FILE_SHADOW_EN adds the accumulator shadow with backup/restore.
module register_file #(
  parameter logic [15:0] SP_RESET = 16'h0000
) (
  input  logic           clk,
  input  logic           rst_n,
  register_file_if.slave rf
);

  logic [15:0] acc_q, acc_d;
  logic [3:0]  page_q, page_d;
  logic [2:0]  cmp_q, cmp_d;
  logic [8:0]  irq_q, irq_d;
  logic [15:0] sp_q, sp_d;
  logic [15:0] ra_q, ra_d;

`ifdef REGISTER_FILE_SHADOW_EN
  logic [15:0] shadow_q, shadow_d;

  // Restore wins over write; backup always captures the pre-edge value
  always_comb begin
    acc_d    = acc_q;
    shadow_d = shadow_q;
    if (rf.r_restore) begin
      acc_d = shadow_q;
    end else if (rf.r_write) begin
      acc_d = rf.r_input;
    end
    if (rf.r_backup) begin
      shadow_d = acc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`else
  logic unused_shadow_ctl;
  assign unused_shadow_ctl = rf.r_backup ^ rf.r_restore;

  always_comb begin
    acc_d = acc_q;
    if (rf.r_write) begin
      acc_d = rf.r_input;
    end
  end
`endif

  always_comb begin
    page_d = page_q;
    cmp_d  = cmp_q;
    irq_d  = irq_q;
    sp_d   = sp_q;
    ra_d   = ra_q;
    if (rf.page_write) begin
      page_d = rf.page_input;
    end
    if (rf.compare_write) begin
      cmp_d = rf.compare_input;
    end
    if (rf.interrupt_write) begin
      irq_d = rf.interrupt_input;
    end
    if (rf.stack_pointer_write) begin
      sp_d = rf.stack_pointer_input;
    end
    if (rf.return_address_write) begin
      ra_d = rf.return_address_input;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      page_q <= '0;
      cmp_q  <= '0;
      irq_q  <= '0;
      sp_q   <= SP_RESET;
      ra_q   <= '0;
    end else begin
      acc_q  <= acc_d;
      page_q <= page_d;
      cmp_q  <= cmp_d;
      irq_q  <= irq_d;
      sp_q   <= sp_d;
      ra_q   <= ra_d;
    end
  end

  assign rf.r_output              = acc_q;
  assign rf.flag_output           = {page_q, irq_q, cmp_q};
  assign rf.stack_pointer_output  = sp_q;
  assign rf.return_address_output = ra_q;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: vector table, directed
// sequences, async reset and randomized traffic against a reference model.
module tb_register_file;

  localparam logic [15:0] SPR = 16'hBEEF;
`ifdef REGISTER_FILE_SHADOW_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  register_file_if rf ();

  register_file #(.SP_RESET(SPR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: plain architectural state
  logic [15:0] m_acc, m_sh, m_sp, m_ra;
  logic [3:0]  m_pg;
  logic [2:0]  m_cm;
  logic [8:0]  m_iq;

  typedef struct {
    logic [3:0]  pg;
    logic        pw;
    logic [2:0]  cm;
    logic        cw;
    logic [8:0]  iq;
    logic        iw;
    logic [15:0] sp;
    logic        spw;
    logic [15:0] ra;
    logic        raw;
    logic [15:0] e_flag;
    logic [15:0] e_sp;
    logic [15:0] e_ra;
  } vec_t;

  vec_t tv[16];

  task automatic chk(string nm, logic [15:0] a, logic [15:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic model_reset();
    m_acc = '0;
    m_sh  = '0;
    m_pg  = '0;
    m_cm  = '0;
    m_iq  = '0;
    m_sp  = SPR;
    m_ra  = '0;
  endtask

  task automatic model_step();
    logic [15:0] a0;
    if (!rst_n) begin
      model_reset();
    end else begin
      a0 = m_acc;
      if (SH && rf.r_restore) m_acc = m_sh;
      else if (rf.r_write)    m_acc = rf.r_input;
      if (SH && rf.r_backup)  m_sh = a0;
      if (rf.page_write)      m_pg = rf.page_input;
      if (rf.compare_write)   m_cm = rf.compare_input;
      if (rf.interrupt_write) m_iq = rf.interrupt_input;
      if (rf.stack_pointer_write)  m_sp = rf.stack_pointer_input;
      if (rf.return_address_write) m_ra = rf.return_address_input;
    end
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".r"}, rf.r_output, m_acc);
    chk({tag, ".flag"}, rf.flag_output, {m_pg, m_iq, m_cm});
    chk({tag, ".sp"}, rf.stack_pointer_output, m_sp);
    chk({tag, ".ra"}, rf.return_address_output, m_ra);
  endtask

  task automatic idle();
    rf.r_input   = 16'hA5A5;
    rf.r_write   = 1'b0;
    rf.r_backup  = 1'b0;
    rf.r_restore = 1'b0;
    rf.page_input    = 4'hF;
    rf.page_write    = 1'b0;
    rf.compare_input = 3'h7;
    rf.compare_write = 1'b0;
    rf.interrupt_input = 9'h1AA;
    rf.interrupt_write = 1'b0;
    rf.stack_pointer_input  = 16'h5A5A;
    rf.stack_pointer_write  = 1'b0;
    rf.return_address_input = 16'h3C3C;
    rf.return_address_write = 1'b0;
  endtask

  task automatic cyc(string tag);
    @(posedge clk);
    model_step();
    #1;
    chk_model(tag);
  endtask

  task automatic acc_op(logic [15:0] d, logic w, logic b, logic r);
    idle();
    rf.r_input   = d;
    rf.r_write   = w;
    rf.r_backup  = b;
    rf.r_restore = r;
    cyc("acc");
  endtask

  initial begin
    logic [15:0] e;

    tv[0]  = '{4'd2, 1, 3'd0, 0, 9'd0, 0, 16'd0, 0, 16'd0, 0,
               16'h2000, SPR, 16'd0};
    tv[1]  = '{4'd3, 0, 3'd0, 0, 9'd0, 0, 16'd0, 0, 16'd0, 0,
               16'h2000, SPR, 16'd0};
    tv[2]  = '{4'd5, 1, 3'd0, 0, 9'd0, 0, 16'd0, 0, 16'd0, 0,
               16'h5000, SPR, 16'd0};
    tv[3]  = '{4'd0, 0, 3'd2, 1, 9'd0, 0, 16'd0, 0, 16'd0, 0,
               16'h5002, SPR, 16'd0};
    tv[4]  = '{4'd0, 0, 3'd3, 0, 9'd0, 0, 16'd0, 0, 16'd0, 0,
               16'h5002, SPR, 16'd0};
    tv[5]  = '{4'd0, 0, 3'd5, 1, 9'd0, 0, 16'd0, 0, 16'd0, 0,
               16'h5005, SPR, 16'd0};
    tv[6]  = '{4'd0, 0, 3'd0, 0, 9'd23, 1, 16'd0, 0, 16'd0, 0,
               16'h50BD, SPR, 16'd0};
    tv[7]  = '{4'd0, 0, 3'd0, 0, 9'd47, 0, 16'd0, 0, 16'd0, 0,
               16'h50BD, SPR, 16'd0};
    tv[8]  = '{4'd0, 0, 3'd0, 0, 9'd35, 1, 16'd0, 0, 16'd0, 0,
               16'h511D, SPR, 16'd0};
    tv[9]  = '{4'd0, 0, 3'd0, 0, 9'd0, 0, 16'd45, 1, 16'd0, 0,
               16'h511D, 16'd45, 16'd0};
    tv[10] = '{4'd0, 0, 3'd0, 0, 9'd0, 0, 16'd21, 0, 16'd0, 0,
               16'h511D, 16'd45, 16'd0};
    tv[11] = '{4'd0, 0, 3'd0, 0, 9'd0, 0, 16'd39, 1, 16'd0, 0,
               16'h511D, 16'd39, 16'd0};
    tv[12] = '{4'd0, 0, 3'd0, 0, 9'd0, 0, 16'd0, 0, 16'd111, 1,
               16'h511D, 16'd39, 16'd111};
    tv[13] = '{4'd0, 0, 3'd0, 0, 9'd0, 0, 16'd0, 0, 16'd25, 0,
               16'h511D, 16'd39, 16'd111};
    tv[14] = '{4'd0, 0, 3'd0, 0, 9'd0, 0, 16'd0, 0, 16'd24, 1,
               16'h511D, 16'd39, 16'd24};
    tv[15] = '{4'hA, 1, 3'd7, 1, 9'h1FF, 1, 16'h1234, 1,
               16'h5678, 1, 16'hAFFF, 16'h1234, 16'h5678};

    rst_n = 1'b0;
    idle();
    model_reset();
    #12;
    chk("reset.r", rf.r_output, 16'h0000);
    chk("reset.flag", rf.flag_output, 16'h0000);
    chk("reset.sp", rf.stack_pointer_output, SPR);
    chk("reset.ra", rf.return_address_output, 16'h0000);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      idle();
      rf.page_input  = tv[i].pg;
      rf.page_write  = tv[i].pw;
      rf.compare_input = tv[i].cm;
      rf.compare_write = tv[i].cw;
      rf.interrupt_input = tv[i].iq;
      rf.interrupt_write = tv[i].iw;
      rf.stack_pointer_input = tv[i].sp;
      rf.stack_pointer_write = tv[i].spw;
      rf.return_address_input = tv[i].ra;
      rf.return_address_write = tv[i].raw;
      cyc("vec");
      chk($sformatf("vec%0d.flag", i), rf.flag_output, tv[i].e_flag);
      chk($sformatf("vec%0d.sp", i),
          rf.stack_pointer_output, tv[i].e_sp);
      chk($sformatf("vec%0d.ra", i),
          rf.return_address_output, tv[i].e_ra);
    end

    // Backup/write/restore walk
    acc_op(16'd5, 1, 0, 0);
    chk("seq_a.w5", rf.r_output, 16'd5);
    acc_op(16'd3, 0, 1, 0);
    chk("seq_a.bk", rf.r_output, 16'd5);
    acc_op(16'd2, 1, 0, 0);
    chk("seq_a.w2", rf.r_output, 16'd2);
    acc_op(16'd0, 0, 0, 1);
    e = SH ? 16'd5 : 16'd2;
    chk("seq_a.rs", rf.r_output, e);
    acc_op(16'd7, 1, 0, 0);
    chk("seq_a.w7", rf.r_output, 16'd7);

    // Swap on simultaneous backup+restore
    acc_op(16'd4, 1, 0, 0);
    acc_op(16'd0, 0, 1, 0);
    acc_op(16'd9, 1, 0, 0);
    acc_op(16'd0, 0, 1, 1);
    e = SH ? 16'd4 : 16'd9;
    chk("swap.1", rf.r_output, e);
    acc_op(16'd0, 0, 0, 1);
    chk("swap.2", rf.r_output, 16'd9);

    // Backup with write: shadow keeps old accumulator
    acc_op(16'h1111, 1, 1, 0);
    chk("bkw.w", rf.r_output, 16'h1111);
    acc_op(16'd0, 0, 0, 1);
    e = SH ? 16'd9 : 16'h1111;
    chk("bkw.rs", rf.r_output, e);

    // Asynchronous reset mid-cycle with every enable high
    rf.r_input = 16'hCAFE;
    rf.r_write = 1'b1;
    rf.r_backup = 1'b1;
    rf.r_restore = 1'b1;
    rf.page_write = 1'b1;
    rf.compare_write = 1'b1;
    rf.interrupt_write = 1'b1;
    rf.stack_pointer_write = 1'b1;
    rf.return_address_write = 1'b1;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst.r", rf.r_output, 16'h0000);
    chk("arst.flag", rf.flag_output, 16'h0000);
    chk("arst.sp", rf.stack_pointer_output, SPR);
    chk("arst.ra", rf.return_address_output, 16'h0000);
    cyc("arst_hold");
    cyc("arst_hold");
    #4;
    rst_n = 1'b1;
    rf.r_restore = 1'b0;
    cyc("arst_rel");
    chk("arst_rel.r", rf.r_output, 16'hCAFE);
    chk("arst_rel.sp", rf.stack_pointer_output, 16'h5A5A);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rf.r_input   = 16'($urandom);
      rf.r_write   = 1'($urandom);
      rf.r_backup  = 1'($urandom);
      rf.r_restore = ($urandom_range(0, 3) == 0);
      rf.page_input    = 4'($urandom);
      rf.page_write    = 1'($urandom);
      rf.compare_input = 3'($urandom);
      rf.compare_write = 1'($urandom);
      rf.interrupt_input = 9'($urandom);
      rf.interrupt_write = 1'($urandom);
      rf.stack_pointer_input  = 16'($urandom);
      rf.stack_pointer_write  = 1'($urandom);
      rf.return_address_input = 16'($urandom);
      rf.return_address_write = 1'($urandom);
      cyc("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
